// File: rtl/pattern_recorder_if.sv
// Purpose: bundles the tap/record controls, beat index and pattern outputs of the pattern recorder.
// Latency: none, this is wiring only.
// Backpressure: none; every signal is a plain level or pulse.
interface pattern_recorder_if;
  logic       tap;
  logic       rec_start;
  logic       clear;
  logic       toggle_en;
  logic [2:0] beat;
  logic [7:0] pattern;
  logic       recording;
  logic       rec_done;

  modport master (
    output tap, rec_start, clear, toggle_en, beat,
    input  pattern, recording, rec_done
  );

  modport slave (
    input  tap, rec_start, clear, toggle_en, beat,
    output pattern, recording, rec_done
  );
endinterface

// File: rtl/pattern_recorder.sv
// Purpose: debounces a tap key, quantizes each tap to the nearest of 8 steps and sets/toggles that pattern bit.
// Latency: raw tap to pattern is 2 sync + DEBOUNCE_CYCLES + 1 edge + 1 update cycles.
// Backpressure: none; inputs are sampled every cycle and taps outside IDLE/RECORD are dropped.
module pattern_recorder #(
  parameter int STEP_CYCLES     = 12500001,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  pattern_recorder_if.slave bus
);

  localparam int PH_W = $clog2(STEP_CYCLES);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [PH_W-1:0] PH_MAX  = PH_W'(STEP_CYCLES - 1);
  localparam logic [PH_W-1:0] PH_HALF = PH_W'(STEP_CYCLES / 2);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ARM, RECORD} state_t;

  logic            sync1_q, sync2_q;
  logic            stable_q, stable_d;
  logic            stable_dly_q;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [2:0]      beat_q;
  logic [PH_W-1:0] phase_q, phase_d;
  state_t          state_q, state_d;
  logic [7:0]      pattern_q, pattern_d;
  logic            recording_q, recording_d;
  logic            rec_done_q, rec_done_d;

  logic            tap_evt;
  logic            beat_tick;
  logic            bar_start;
  logic [2:0]      tgt;

  // Tap conditioning, step-phase tracking and tap-to-step quantization.
  always_comb begin
    stable_d = stable_q;
    db_cnt_d = '0;
    if (sync2_q != stable_q) begin
      if (db_cnt_q == DB_LAST) begin
        stable_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
    // Only presses count as taps; releases are filtered here.
    tap_evt   = stable_q & ~stable_dly_q;
    beat_tick = (bus.beat != beat_q);
    bar_start = beat_tick && (bus.beat == 3'd0);
    if (beat_tick) begin
      phase_d = '0;
    end else if (phase_q == PH_MAX) begin
      phase_d = phase_q;
    end else begin
      phase_d = phase_q + PH_W'(1);
    end
    // Late taps round up to the next step; 3-bit add wraps step 7 to step 0.
    tgt = (phase_q < PH_HALF) ? beat_q : beat_q + 3'd1;
  end

  // Record-mode FSM and pattern writes; clear overrides every write.
  always_comb begin
    state_d    = state_q;
    pattern_d  = pattern_q;
    rec_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (tap_evt && bus.toggle_en) pattern_d[tgt] = ~pattern_q[tgt];
        if (bus.rec_start) state_d = ARM;
      end
      ARM: begin
        if (bar_start) begin
          state_d   = RECORD;
          pattern_d = '0;
        end
      end
      RECORD: begin
        if (tap_evt) pattern_d[tgt] = 1'b1;
        if (bar_start) begin
          state_d    = IDLE;
          rec_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.clear) pattern_d = '0;
    recording_d = (state_d == RECORD);
  end

  // All state registers, synchronous active-high reset.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      db_cnt_q     <= '0;
      beat_q       <= 3'd0;
      phase_q      <= '0;
      state_q      <= IDLE;
      pattern_q    <= 8'h00;
      recording_q  <= 1'b0;
      rec_done_q   <= 1'b0;
    end else begin
      sync1_q      <= bus.tap;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      db_cnt_q     <= db_cnt_d;
      beat_q       <= bus.beat;
      phase_q      <= phase_d;
      state_q      <= state_d;
      pattern_q    <= pattern_d;
      recording_q  <= recording_d;
      rec_done_q   <= rec_done_d;
    end
  end

  assign bus.pattern   = pattern_q;
  assign bus.recording = recording_q;
  assign bus.rec_done  = rec_done_q;

endmodule

// File: tb/tb_pattern_recorder.sv
// Purpose: directed self-checking bench for pattern_recorder with a 100-cycle beat model.
// Latency: checks are taken well after each tap has propagated.
// Backpressure: none; stimulus is driven half a cycle away from the sampling edge.
module tb_pattern_recorder;

  logic clk = 1'b0;
  logic reset;
  int   tb_cyc;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_done;

  pattern_recorder_if bus();

  pattern_recorder #(
    .STEP_CYCLES     (100),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus)
  );

  always #10 clk = ~clk;

  // Beat model: advances the step index every 100 cycles on the falling edge.
  initial begin
    bus.beat = 3'd0;
    tb_cyc   = 0;
    forever begin
      @(negedge clk);
      if (tb_cyc == 99) begin
        tb_cyc   = 0;
        bus.beat = bus.beat + 3'd1;
      end else begin
        tb_cyc = tb_cyc + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_for(input int b, input int ph);
    bit found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      step();
      if (bus.beat == 3'(b) && tb_cyc == ph) found = 1'b1;
    end
    if (!found) check($sformatf("wait_b%0d_p%0d", b, ph), 32'(found), 32'd1);
  endtask

  task automatic tap_once();
    bus.tap = 1'b1;
    repeat (8) step();
    bus.tap = 1'b0;
    repeat (8) step();
  endtask

  task automatic pulse_start();
    bus.rec_start = 1'b1;
    step();
    bus.rec_start = 1'b0;
  endtask

  task automatic count_done(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.rec_done) n++;
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.tap       = 1'b0;
    bus.rec_start = 1'b0;
    bus.clear     = 1'b0;
    bus.toggle_en = 1'b0;
    repeat (5) step();
    reset = 1'b0;
    step();
    check("rst_pattern",   32'(bus.pattern),   32'h00);
    check("rst_recording", 32'(bus.recording), 32'd0);
    check("rst_rec_done",  32'(bus.rec_done),  32'd0);

    // Bounce shorter than the debounce window
    bus.tap = 1'b1; step();
    bus.tap = 1'b0; step();
    bus.tap = 1'b1; step();
    bus.tap = 1'b0;
    repeat (12) step();
    check("bounce_ignored", 32'(bus.pattern), 32'h00);

    // Toggle edits in IDLE
    bus.toggle_en = 1'b1;
    wait_for(3, 3);  tap_once();
    check("toggle_b3_on", 32'(bus.pattern), 32'h08);
    wait_for(3, 3);  tap_once();
    check("toggle_b3_off", 32'(bus.pattern), 32'h00);
    wait_for(7, 53); tap_once();
    check("late_b7_wraps", 32'(bus.pattern), 32'h01);
    wait_for(7, 53); tap_once();
    check("late_b7_back", 32'(bus.pattern), 32'h00);
    bus.toggle_en = 1'b0;
    wait_for(7, 53); tap_once();
    check("toggle_disabled", 32'(bus.pattern), 32'h00);

    // Preload all steps, then a record pass
    bus.toggle_en = 1'b1;
    for (int b = 0; b < 8; b++) begin
      wait_for(b, 3);
      tap_once();
    end
    check("preload_ff", 32'(bus.pattern), 32'hFF);
    wait_for(5, 10); pulse_start();
    step();
    check("arm_not_recording", 32'(bus.recording), 32'd0);
    check("arm_keeps_pattern", 32'(bus.pattern),   32'hFF);
    wait_for(0, 2);
    check("rec_entry_clear", 32'(bus.pattern),   32'h00);
    check("rec_entry_flag",  32'(bus.recording), 32'd1);
    wait_for(2, 13); tap_once();
    wait_for(4, 63); tap_once();
    check("rec_taps", 32'(bus.pattern), 32'h24);
    wait_for(7, 90); count_done(n_done);
    check("rec_done_once",  32'(n_done),        32'd1);
    check("rec_end_flag",   32'(bus.recording), 32'd0);
    check("rec_end_keep",   32'(bus.pattern),   32'h24);

    // Record pass with clear held; rec_start inside RECORD is ignored
    wait_for(1, 10); pulse_start();
    wait_for(7, 50); bus.clear = 1'b1;
    wait_for(0, 3);
    check("clr_rec_flag", 32'(bus.recording), 32'd1);
    check("clr_entry",    32'(bus.pattern),   32'h00);
    wait_for(3, 3);  tap_once();
    check("clr_tap_blocked", 32'(bus.pattern), 32'h00);
    wait_for(5, 10); pulse_start();
    wait_for(7, 90); count_done(n_done);
    check("clr_done_once", 32'(n_done),        32'd1);
    check("clr_end_flag",  32'(bus.recording), 32'd0);
    check("clr_end_pat",   32'(bus.pattern),   32'h00);
    bus.clear = 1'b0;
    wait_for(1, 10);
    wait_for(0, 50);
    check("rec_start_in_rec_ignored", 32'(bus.recording), 32'd0);

    // Reset in the middle of a record pass
    wait_for(2, 10); pulse_start();
    wait_for(1, 3);  tap_once();
    check("pre_reset_tap", 32'(bus.pattern), 32'h02);
    reset = 1'b1;
    step();
    check("mid_rst_pattern",   32'(bus.pattern),   32'h00);
    check("mid_rst_recording", 32'(bus.recording), 32'd0);
    check("mid_rst_rec_done",  32'(bus.rec_done),  32'd0);
    reset = 1'b0;
    wait_for(7, 90); count_done(n_done);
    check("mid_rst_no_done", 32'(n_done),        32'd0);
    check("mid_rst_idle",    32'(bus.recording), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pattern_recorder.md
Name: pattern_recorder

Overview:
- Live step-entry writer for the 8-step drum pattern.
- Debounces a tap key and quantizes each tap to the nearest sequencer step using the beat index broadcast by the note player.
- Sets or toggles that step's bit in an 8-bit pattern register.
- The pattern output drives the note player's step-enable input in place of raw switches; it supports one-bar record passes and free-running toggle edits.

Parameters:
- STEP_CYCLES, 12500001, clock cycles per sequencer step; must match the note player's step period.
- DEBOUNCE_CYCLES, 500000, number of consecutive cycles the synchronized tap must hold a level before it is accepted (10 ms).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high.
- tap  in  1  raw tap key, active-high, asynchronous and bouncy.
- rec_start  in  1  single-cycle pulse; arms a one-bar record pass.
- clear  in  1  level; while high, forces pattern to 0.
- toggle_en  in  1  1 = taps in IDLE toggle the step bit; 0 = taps in IDLE are ignored.
- beat  in  3  current step index from the note player; 0..7, wraps 7->0.
- pattern  out  8  step-enable pattern; bit n enables step n.
- recording  out  1  high while in the RECORD state.
- rec_done  out  1  single-cycle pulse when a record pass completes.

Behaviour:
- Reset
  - pattern=0, recording=0, rec_done=0, state=IDLE.
  - Sync flops, debounce counter, stable level, beat_q and phase all go to 0.
  - Reset mid-record discards the pass entirely.
- Tap conditioning
  - tap passes through a 2-flop synchronizer.
  - The stable level updates only after the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive cycles; the counter restarts on any mismatch break.
  - A tap event is a one-cycle pulse on the 0->1 transition of the stable level; releases produce no event.
- Step tracking
  - beat_q registers beat every cycle; beat_tick = (beat != beat_q).
  - phase clears to 0 in the cycle after beat_tick, otherwise increments and saturates at STEP_CYCLES-1.
- Quantization, evaluated in the cycle the tap event is high
  - tgt = beat_q if phase < STEP_CYCLES/2 (integer divide), else (beat_q+1) mod 8.
  - The 3-bit wrap is required: a late tap in step 7 maps to step 0.
- FSM: IDLE, ARM, RECORD
  - IDLE: a tap event with toggle_en=1 toggles pattern[tgt]. rec_start -> ARM.
  - ARM: taps are ignored. On beat_tick with beat==0 -> RECORD; pattern clears to 0 in that same transition.
  - RECORD: recording=1; a tap event sets pattern[tgt]=1 (never clears). On beat_tick with beat==0 -> IDLE, and rec_done=1 for exactly one cycle.
  - rec_start is ignored in ARM and RECORD.
- Latency
  - pattern updates on the clock edge after the tap-event cycle.
  - Raw tap to pattern: 2 sync cycles + DEBOUNCE_CYCLES + 1 edge cycle + 1 update cycle.
- Simultaneous events
  - clear has priority over every pattern write, including the RECORD entry clear. While clear is high the state still advances normally.
  - A tap event in the same cycle as the RECORD->IDLE transition is still applied as a RECORD write (set).
  - Two tap events mapping to the same step in RECORD leave the bit at 1. In IDLE with toggle_en=1 they toggle it twice.

Test Plan (use STEP_CYCLES=100, DEBOUNCE_CYCLES=4; drive beat from a model stepping every 100 cycles):
- Reset -> pattern=0x00, recording=0, rec_done=0; tap bouncing 1,0,1,0 at 1-cycle intervals -> no tap event, pattern unchanged.
- IDLE, toggle_en=1, clean tap at phase 10 of beat 3 -> pattern=0x08; repeat the same tap -> pattern=0x00.
- IDLE, toggle_en=1, tap at phase 60 of beat 7 -> pattern=0x01 (wrap to step 0); with toggle_en=0 the same tap leaves pattern=0x00.
- Preload 0xFF via toggles, pulse rec_start at beat 5 -> ARM; at beat 0 -> pattern=0x00 and recording=1.
  - Taps at beat 2 phase 20 and beat 4 phase 70 -> pattern=0x24.
  - Next 7->0 transition -> recording=0, rec_done pulses exactly one cycle.
- During RECORD, hold clear high while tapping -> pattern stays 0x00 and the FSM still ends on schedule. Pulse rec_start in RECORD -> no effect.
- Assert reset mid-RECORD after a tap -> next cycle pattern=0x00, recording=0, state IDLE, no rec_done pulse.
